// File: rtl/pc_seq_pkg.sv
// Shared encodings for the next-PC sequencer: control-op codes, FSM states, default widths.
package pc_seq_pkg;

  localparam int unsigned PcWDefault = 8;

  typedef enum logic [2:0] {
    OpSeq  = 3'd0,
    OpBr   = 3'd1,
    OpJmp  = 3'd2,
    OpCall = 3'd3,
    OpRet  = 3'd4
  } ctl_op_e;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StBubble
  } seq_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = PcWDefault,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            underflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] top_ptr;
  logic [CntW-1:0] cnt_q;

  assign top_ptr   = wr_ptr_q - PtrW'(1);
  assign top_data  = mem_q[top_ptr];
  assign full      = (cnt_q == CntW'(RAS_DEPTH));
  assign empty     = (cnt_q == '0);
  assign overflow  = push && full;
  assign underflow = pop && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      // When full the write slot is the oldest entry, so the count saturates.
      mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      if (!full) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end else if (pop && !empty) begin
      wr_ptr_q <= top_ptr;
      cnt_q    <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller with one-bubble redirects. Define PC_SEQ_RAS_EN to add the
// hardware return-address stack; otherwise CALL/RET behave as JMP.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned    PC_W      = PcWDefault,
  parameter int unsigned    RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] fetch_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            ctl_valid,
  output logic            ctl_ready,
  input  logic [2:0]      ctl_op,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_offset,
  input  logic [PC_W-1:0] jmp_target,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic            fire;
  ctl_op_e         op;

  assign op          = ctl_op_e'(ctl_op);
  assign fetch_pc    = pc_q;
  assign fetch_valid = (state_q == StRun);
  assign ctl_ready   = fetch_valid && fetch_ready;
  assign fire        = ctl_valid && ctl_ready;
  assign pc_inc      = pc_q + PC_W'(1);

`ifdef PC_SEQ_RAS_EN
  logic            ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_full, ras_empty, ras_ovf_pulse, ras_unf_pulse;
  logic            ovf_q, unf_q;

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_ovf_pulse),
    .underflow (ras_unf_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ras_ovf_pulse;
      unf_q <= unf_q | ras_unf_pulse;
    end
  end

  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
`else
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_SEQ_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`endif
    unique case (state_q)
      StBoot:   state_d = StRun;
      StRun: begin
        if (fire) begin
          pc_d = pc_inc;
          // Unlisted encodings fall through as SEQ.
          case (op)
            OpBr: begin
              if (br_taken) begin
                pc_d    = pc_q + br_offset;
                state_d = StBubble;
              end
            end
            OpJmp: begin
              pc_d    = jmp_target;
              state_d = StBubble;
            end
            OpCall: begin
              pc_d    = jmp_target;
              state_d = StBubble;
`ifdef PC_SEQ_RAS_EN
              ras_push = 1'b1;
`endif
            end
            OpRet: begin
`ifdef PC_SEQ_RAS_EN
              ras_pop = 1'b1;
              pc_d    = ras_empty ? RESET_PC : ras_top;
`else
              pc_d    = jmp_target;
`endif
              state_d = StBubble;
            end
            default: ;
          endcase
        end
      end
      StBubble: state_d = StRun;
      default:  state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus randomized ops vs a queue-based model.
module tb_pc_sequencer;

  localparam int unsigned PC_W      = 8;
  localparam int unsigned RAS_DEPTH = 4;
  localparam logic [7:0]  RESET_PC  = 8'h00;

  logic       clk;
  logic       rst_n;
  logic [7:0] fetch_pc;
  logic       fetch_valid;
  logic       fetch_ready;
  logic       ctl_valid;
  logic       ctl_ready;
  logic [2:0] ctl_op;
  logic       br_taken;
  logic [7:0] br_offset;
  logic [7:0] jmp_target;
  logic       ras_overflow;
  logic       ras_underflow;

  pc_sequencer #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_pc      (fetch_pc),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .ctl_valid     (ctl_valid),
    .ctl_ready     (ctl_ready),
    .ctl_op        (ctl_op),
    .br_taken      (br_taken),
    .br_offset     (br_offset),
    .jmp_target    (jmp_target),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the DUT must show at the next firing: PC, invalid cycles since the last firing, flags.
  typedef struct {
    logic [7:0] pc;
    int         bubbles;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;

  logic [7:0] m_pc;
  logic [7:0] m_ras[$];
  bit         m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_step(input logic [2:0] op, input bit tk,
                                     input logic [7:0] off, input logic [7:0] tgt);
    logic [7:0] nxt;
    int         redir;
    nxt   = m_pc + 8'd1;
    redir = 0;
    case (op)
      3'd1: if (tk) begin nxt = m_pc + off; redir = 1; end
      3'd2: begin nxt = tgt; redir = 1; end
      3'd3: begin
`ifdef PC_SEQ_RAS_EN
        if (m_ras.size() == RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(m_pc + 8'd1);
`endif
        nxt = tgt; redir = 1;
      end
      3'd4: begin
`ifdef PC_SEQ_RAS_EN
        if (m_ras.size() == 0) begin
          nxt   = RESET_PC;
          m_unf = 1'b1;
        end else begin
          nxt = m_ras.pop_back();
        end
`else
        nxt = tgt;
`endif
        redir = 1;
      end
      default: ;
    endcase
    m_pc = nxt;
    exp_q.push_back('{pc: nxt, bubbles: redir, ovf: m_ovf, unf: m_unf});
  endfunction

  // Monitor: compares at every firing, plus handshake and stall-stability rules each cycle.
  initial begin
    int         inv_cnt;
    bit         prev_valid, prev_fire, fire;
    logic [7:0] prev_pc;
    exp_t       e;
    inv_cnt    = 0;
    prev_valid = 1'b0;
    prev_fire  = 1'b0;
    prev_pc    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inv_cnt    = 0;
        prev_valid = 1'b0;
        prev_fire  = 1'b0;
      end else begin
        check("ctl_ready", ctl_ready, fetch_valid && fetch_ready);
        if (fetch_valid && prev_valid && !prev_fire) check("stall_pc", fetch_pc, prev_pc);
        fire = fetch_valid && fetch_ready && ctl_valid;
        if (fire) begin
          if (exp_q.size() == 0) begin
            check("sb_nonempty", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("fetch_pc", fetch_pc, e.pc);
            check("bubbles", inv_cnt, e.bubbles);
            check("ras_overflow", ras_overflow, e.ovf);
            check("ras_underflow", ras_underflow, e.unf);
          end
          inv_cnt = 0;
        end else if (!fetch_valid) begin
          inv_cnt++;
        end
        prev_valid = fetch_valid;
        prev_pc    = fetch_pc;
        prev_fire  = fire;
      end
    end
  end

  task automatic drive_cycle(input bit v, input bit rdy, input logic [2:0] op, input bit tk,
                             input logic [7:0] off, input logic [7:0] tgt, output bit fired);
    @(posedge clk);
    #1;
    ctl_valid   = v;
    fetch_ready = rdy;
    ctl_op      = op;
    br_taken    = tk;
    br_offset   = off;
    jmp_target  = tgt;
    @(negedge clk);
    fired = v && rdy && fetch_valid && rst_n;
    if (fired) model_step(op, tk, off, tgt);
  endtask

  task automatic issue(input logic [2:0] op, input bit tk, input logic [7:0] off,
                       input logic [7:0] tgt);
    bit f;
    f = 1'b0;
    for (int i = 0; i < 16 && !f; i++) begin
      drive_cycle(1'b1, 1'b1, op, tk, off, tgt, f);
    end
    if (!f) check("issue_timeout", 0, 1);
  endtask

  task automatic stall(input int n);
    bit f;
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, f);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    ctl_valid = 1'b0;
    exp_q.delete();
    m_ras.delete();
    m_pc  = RESET_PC;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    exp_q.push_back('{pc: RESET_PC, bubbles: 1, ovf: 1'b0, unf: 1'b0});
    #1;
    check("rst_fetch_pc", fetch_pc, RESET_PC);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_ovf", ras_overflow, 0);
    check("rst_unf", ras_underflow, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit f;
    rst_n       = 1'b0;
    ctl_valid   = 1'b0;
    fetch_ready = 1'b1;
    ctl_op      = 3'd0;
    br_taken    = 1'b0;
    br_offset   = 8'h00;
    jmp_target  = 8'h00;

    do_reset();
    for (int i = 0; i < 4; i++) issue(3'd0, 1'b0, 8'h00, 8'h00);

    // Wrap-around and negative branch displacement.
    issue(3'd2, 1'b0, 8'h00, 8'hFF);
    issue(3'd0, 1'b0, 8'h00, 8'h00);
    issue(3'd0, 1'b0, 8'h00, 8'h00);
    issue(3'd0, 1'b0, 8'h00, 8'h00);
    issue(3'd1, 1'b1, 8'hFC, 8'h00);

    // Stall at 0x10, then branch not taken.
    issue(3'd2, 1'b0, 8'h00, 8'h10);
    stall(4);
    issue(3'd1, 1'b0, 8'h33, 8'h00);
    issue(3'd0, 1'b0, 8'h00, 8'h00);

    // Nested calls and returns.
    issue(3'd2, 1'b0, 8'h00, 8'h20);
    issue(3'd3, 1'b0, 8'h00, 8'h40);
    issue(3'd3, 1'b0, 8'h00, 8'h60);
    issue(3'd4, 1'b0, 8'h00, 8'hA1);
    issue(3'd4, 1'b0, 8'h00, 8'hA2);
    issue(3'd0, 1'b0, 8'h00, 8'h00);

    // Overflow then underflow of the stack.
    for (int i = 0; i < 5; i++) issue(3'd3, 1'b0, 8'h00, 8'(8'h80 + i * 8));
    for (int i = 0; i < 5; i++) issue(3'd4, 1'b0, 8'h00, 8'(8'hC0 + i));
    issue(3'd0, 1'b0, 8'h00, 8'h00);

    // Randomized traffic after a fresh reset.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive_cycle(($urandom % 4) != 0, ($urandom % 4) != 0, 3'($urandom % 8),
                  1'($urandom % 2), 8'($urandom), 8'($urandom), f);
    end
    issue(3'd0, 1'b0, 8'h00, 8'h00);

    // Reset in the middle of a bubble with a populated stack.
    do_reset();
    issue(3'd3, 1'b0, 8'h00, 8'h30);
    issue(3'd3, 1'b0, 8'h00, 8'h50);
    issue(3'd2, 1'b0, 8'h00, 8'h55);
    do_reset();
    issue(3'd4, 1'b0, 8'h00, 8'h77);
    issue(3'd0, 1'b0, 8'h00, 8'h00);
    issue(3'd0, 1'b0, 8'h00, 8'h00);
    issue(3'd0, 1'b0, 8'h00, 8'h00);

    ctl_valid = 1'b0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
